// File: rtl/mpaddsub_seq.sv
// Multi-precision adder/subtractor working CHUNK bits per cycle, LSB first.
// The carry between chunks is registered, so the carry chain stays CHUNK bits long for any WIDTH.
module mpaddsub_seq #(
  parameter int WIDTH = 1027,
  parameter int CHUNK = 128
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH:0]   result,
  output logic             busy,
  output logic             done
);
  localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int PW     = NCHUNK * CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [PW-1:0]   a_reg, b_reg;
  logic            carry_reg, sub_reg;
  logic [CW-1:0]   cnt_reg;
  logic [WIDTH:0]  result_reg;

  logic            accept;
  logic            last_chunk;
  logic [PW-1:0]   a_pad, b_pad;
  logic [CHUNK:0]  chunk_sum;
  logic [PW-1:0]   acc_next;
  logic [WIDTH:0]  result_next;

  assign last_chunk = (cnt_reg == LAST);
  assign chunk_sum  = {1'b0, a_reg[CHUNK-1:0]} + {1'b0, b_reg[CHUNK-1:0]}
                    + (CHUNK+1)'(carry_reg);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          accept     = 1'b1;
        end
      end
      RUN: begin
        if (last_chunk) state_next = DONE;
      end
      DONE: begin
        accept     = start;
        state_next = start ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operands are zero-padded to whole chunks; subtraction inverts the padded B.
  always_comb begin
    a_pad = '0;
    a_pad[WIDTH-1:0] = in_a;
    b_pad = '0;
    b_pad[WIDTH-1:0] = in_b;
    if (subtract) b_pad = ~b_pad;
  end

  // The accumulator only holds the chunks above the one being produced this cycle.
  generate
    if (NCHUNK == 1) begin : g_single
      assign acc_next = chunk_sum[CHUNK-1:0];
    end else begin : g_multi
      logic [PW-CHUNK-1:0] acc_reg;
      assign acc_next = {chunk_sum[CHUNK-1:0], acc_reg};
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)              acc_reg <= '0;
        else if (state_reg == RUN) acc_reg <= acc_next[PW-1:CHUNK];
      end
    end
  endgenerate

  // With pad bits, bit WIDTH of the padded sum is already the modular answer.
  // Without them it is the raw carry-out, which is inverted for a borrow.
  generate
    if (PW > WIDTH) begin : g_padded
      logic unused_pad;
      assign result_next = acc_next[WIDTH:0];
      assign unused_pad  = ^{acc_next[PW-1:WIDTH], sub_reg};
    end else begin : g_exact
      assign result_next = {chunk_sum[CHUNK] ^ sub_reg, acc_next};
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_reg      <= '0;
      b_reg      <= '0;
      carry_reg  <= 1'b0;
      sub_reg    <= 1'b0;
      cnt_reg    <= '0;
      result_reg <= '0;
    end else if (accept) begin
      a_reg     <= a_pad;
      b_reg     <= b_pad;
      carry_reg <= subtract;
      sub_reg   <= subtract;
      cnt_reg   <= '0;
    end else if (state_reg == RUN) begin
      a_reg     <= a_reg >> CHUNK;
      b_reg     <= b_reg >> CHUNK;
      carry_reg <= chunk_sum[CHUNK];
      cnt_reg   <= cnt_reg + CW'(1);
      if (last_chunk) result_reg <= result_next;
    end
  end

  assign result = result_reg;
  assign busy   = (state_reg == RUN);
  assign done   = (state_reg == DONE);

endmodule

// File: tb/tb_mpaddsub_seq.sv
// Bench for mpaddsub_seq: directed scenarios on the 1027/128 build plus random
// regressions on four WIDTH/CHUNK builds against a plain-arithmetic model.
module tb_mpaddsub_seq;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic st0 = 1'b0, sb0 = 1'b0, bz0, dn0;
  logic [1026:0] a0 = '0, b0 = '0;
  logic [1027:0] r0;
  logic st1 = 1'b0, sb1 = 1'b0, bz1, dn1;
  logic [1026:0] a1 = '0, b1 = '0;
  logic [1027:0] r1;
  logic st2 = 1'b0, sb2 = 1'b0, bz2, dn2;
  logic [63:0] a2 = '0, b2 = '0;
  logic [64:0] r2;
  logic st3 = 1'b0, sb3 = 1'b0, bz3, dn3;
  logic [7:0] a3 = '0, b3 = '0;
  logic [8:0] r3;

  mpaddsub_seq #(.WIDTH(1027), .CHUNK(128)) dut0 (
    .clk(clk), .resetn(resetn), .start(st0), .subtract(sb0), .in_a(a0), .in_b(b0),
    .result(r0), .busy(bz0), .done(dn0));
  mpaddsub_seq #(.WIDTH(1027), .CHUNK(1027)) dut1 (
    .clk(clk), .resetn(resetn), .start(st1), .subtract(sb1), .in_a(a1), .in_b(b1),
    .result(r1), .busy(bz1), .done(dn1));
  mpaddsub_seq #(.WIDTH(64), .CHUNK(7)) dut2 (
    .clk(clk), .resetn(resetn), .start(st2), .subtract(sb2), .in_a(a2), .in_b(b2),
    .result(r2), .busy(bz2), .done(dn2));
  mpaddsub_seq #(.WIDTH(8), .CHUNK(1)) dut3 (
    .clk(clk), .resetn(resetn), .start(st3), .subtract(sb3), .in_a(a3), .in_b(b3),
    .result(r3), .busy(bz3), .done(dn3));

  int n_pass = 0;
  int n_total = 0;

  function automatic int cfg_width(int k);
    case (k)
      0, 1:    return 1027;
      2:       return 64;
      default: return 8;
    endcase
  endfunction

  // ceil(WIDTH/CHUNK): 1027/128, 1027/1027, 64/7, 8/1
  function automatic int cfg_nchunk(int k);
    case (k)
      0:       return 9;
      1:       return 1;
      2:       return 10;
      default: return 8;
    endcase
  endfunction

  function automatic logic [1027:0] ref_model(int w, logic [1026:0] a, logic [1026:0] b, bit sub);
    logic [1028:0] full, mask, t;
    full = sub ? ({2'b00, a} - {2'b00, b}) : ({2'b00, a} + {2'b00, b});
    mask = '1;
    mask = ~(mask << (w + 1));
    t = full & mask;
    return t[1027:0];
  endfunction

  function automatic logic [1026:0] rand_op(int w);
    logic [1055:0] raw;
    logic [1026:0] v, ones;
    for (int i = 0; i < 33; i++) raw[i*32 +: 32] = $urandom;
    case ($urandom_range(0, 7))
      0:       v = '1;
      1:       v = '0;
      2:       v = 1027'($urandom_range(0, 15));
      3:       v = ~1027'($urandom_range(0, 3));
      default: v = raw[1026:0];
    endcase
    ones = '1;
    return v & ~(ones << w);
  endfunction

  task automatic drive(input int k, input logic [1026:0] a, input logic [1026:0] b, input bit sub);
    case (k)
      0: begin a0 = a; b0 = b; sb0 = sub; end
      1: begin a1 = a; b1 = b; sb1 = sub; end
      2: begin a2 = a[63:0]; b2 = b[63:0]; sb2 = sub; end
      default: begin a3 = a[7:0]; b3 = b[7:0]; sb3 = sub; end
    endcase
  endtask

  task automatic set_start(input int k, input bit v);
    case (k)
      0: st0 = v;
      1: st1 = v;
      2: st2 = v;
      default: st3 = v;
    endcase
  endtask

  function automatic logic [1027:0] get_res(int k);
    logic [1027:0] t;
    t = '0;
    case (k)
      0: t = r0;
      1: t = r1;
      2: t[64:0] = r2;
      default: t[8:0] = r3;
    endcase
    return t;
  endfunction

  function automatic logic get_done(int k);
    case (k)
      0: return dn0;
      1: return dn1;
      2: return dn2;
      default: return dn3;
    endcase
  endfunction

  function automatic logic get_busy(int k);
    case (k)
      0: return bz0;
      1: return bz1;
      2: return bz2;
      default: return bz3;
    endcase
  endfunction

  // Issues one operation and waits for done. lat counts edges from the edge that
  // samples start to the edge that captures done; returns #1 after the done edge.
  task automatic run_op(input int k, input logic [1026:0] a, input logic [1026:0] b, input bit sub,
                        output logic [1027:0] res, output int lat, output int busy_cycles, output bit ok);
    drive(k, a, b, sub);
    set_start(k, 1'b1);
    @(posedge clk); #1;
    set_start(k, 1'b0);
    busy_cycles = get_busy(k) ? 1 : 0;
    ok = 1'b0;
    lat = 0;
    res = '0;
    for (int e = 1; e <= 2000; e++) begin
      @(posedge clk); #1;
      if (get_done(k)) begin
        ok = 1'b1;
        lat = e + 1;
        res = get_res(k);
        break;
      end
      if (get_busy(k)) busy_cycles++;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (r0 !== 1028'd0) $display("FAIL reset_result: got lo=%h, expected 0", r0[63:0]); else n_pass++;
    n_total++;
    if (dn0 !== 1'b0) $display("FAIL reset_done: got %b, expected 0", dn0); else n_pass++;
    n_total++;
    if (bz0 !== 1'b0) $display("FAIL reset_busy: got %b, expected 0", bz0); else n_pass++;
    n_total++;
    if (r2 !== 65'd0) $display("FAIL reset_result_64: got %h, expected 0", r2); else n_pass++;
    resetn = 1'b1;
    @(posedge clk); #1;
    $display("reset released");
  endtask

  task automatic test_add_carry();
    logic [1026:0] a, b;
    logic [1027:0] res, exp;
    int lat, bc;
    bit ok;
    a = '1;
    b = 1027'd1;
    exp = '0;
    exp[1027] = 1'b1;
    run_op(0, a, b, 1'b0, res, lat, bc, ok);
    $display("add (2^1027-1)+1 lat=%0d busy=%0d", lat, bc);
    n_total++;
    if (ok !== 1'b1) $display("FAIL add_carry_timeout: done not seen, expected within 2000 cycles"); else n_pass++;
    n_total++;
    if (res !== exp)
      $display("FAIL add_carry_result: got hi=%h lo=%h, expected hi=%h lo=%h", res[1027:960], res[63:0], exp[1027:960], exp[63:0]);
    else n_pass++;
    n_total++;
    if (lat !== 10) $display("FAIL add_carry_latency: got %0d, expected 10", lat); else n_pass++;
    n_total++;
    if (bc !== 9) $display("FAIL add_carry_busy_cycles: got %0d, expected 9", bc); else n_pass++;
    n_total++;
    if (bz0 !== 1'b0) $display("FAIL done_busy_overlap: busy got %b with done high, expected 0", bz0); else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (dn0 !== 1'b0) $display("FAIL done_pulse_width: done got %b one cycle later, expected 0", dn0); else n_pass++;
    n_total++;
    if (r0 !== exp) $display("FAIL result_hold_idle: got hi=%h, expected hi=%h", r0[1027:960], exp[1027:960]); else n_pass++;
  endtask

  task automatic test_subtract();
    logic [1027:0] res, exp;
    int lat, bc;
    bit ok;
    exp = '1;
    exp[0] = 1'b0;
    run_op(0, 1027'd5, 1027'd7, 1'b1, res, lat, bc, ok);
    $display("sub 5-7 ok=%0d lat=%0d", ok, lat);
    n_total++;
    if (res !== exp)
      $display("FAIL sub_5_7_result: got hi=%h lo=%h, expected hi=%h lo=%h", res[1027:960], res[63:0], exp[1027:960], exp[63:0]);
    else n_pass++;
    n_total++;
    if (res[1027] !== 1'b1) $display("FAIL sub_5_7_borrow: got %b, expected 1", res[1027]); else n_pass++;
    @(posedge clk); #1;
    run_op(0, 1027'd7, 1027'd5, 1'b1, res, lat, bc, ok);
    $display("sub 7-5 ok=%0d lat=%0d", ok, lat);
    n_total++;
    if (res !== 1028'd2)
      $display("FAIL sub_7_5_result: got hi=%h lo=%h, expected 2", res[1027:960], res[63:0]);
    else n_pass++;
    n_total++;
    if (res[1027] !== 1'b0) $display("FAIL sub_7_5_borrow: got %b, expected 0", res[1027]); else n_pass++;
  endtask

  task automatic test_ripple();
    logic [1026:0] a;
    logic [1027:0] res;
    logic [1151:0] rw, ew;
    int lat, bc;
    bit ok;
    a = '0;
    for (int i = 0; i < 1024; i++) a[i] = 1'b1;
    a[1026] = 1'b1;
    ew = '0;
    ew[1026] = 1'b1;
    ew[1024] = 1'b1;
    @(posedge clk); #1;
    run_op(0, a, 1027'd1, 1'b0, res, lat, bc, ok);
    $display("ripple add ok=%0d lat=%0d", ok, lat);
    rw = '0;
    rw[1027:0] = res;
    for (int c = 0; c < 9; c++) begin
      n_total++;
      if (rw[c*128 +: 128] !== ew[c*128 +: 128])
        $display("FAIL ripple_chunk%0d: got %h, expected %h", c, rw[c*128 +: 128], ew[c*128 +: 128]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [1026:0] xa1, xb1, xa2, xb2, xa3, xb3;
    logic [1027:0] exp1, exp2, exp3;
    bit s1, s2, s3, ok, ok2, held;
    int lat, gap, extra;
    xa1 = rand_op(1027); xb1 = rand_op(1027); s1 = 1'($urandom_range(0, 1));
    xa2 = rand_op(1027); xb2 = rand_op(1027); s2 = 1'($urandom_range(0, 1));
    exp1 = ref_model(1027, xa1, xb1, s1);
    exp2 = ref_model(1027, xa2, xb2, s2);
    @(posedge clk); #1;
    drive(0, xa1, xb1, s1);
    st0 = 1'b1;
    @(posedge clk); #1;
    // start stays high through RUN (ignored) and DONE (accepted with op2)
    drive(0, xa2, xb2, s2);
    ok = 1'b0;
    lat = 0;
    for (int e = 1; e <= 100; e++) begin
      @(posedge clk); #1;
      if (dn0) begin ok = 1'b1; lat = e + 1; break; end
    end
    $display("b2b op1 ok=%0d lat=%0d", ok, lat);
    n_total++;
    if (ok !== 1'b1 || lat !== 10) $display("FAIL b2b_first_done: ok=%0d lat got %0d, expected 10", ok, lat); else n_pass++;
    n_total++;
    if (r0 !== exp1)
      $display("FAIL b2b_first_result: got hi=%h lo=%h, expected hi=%h lo=%h", r0[1027:960], r0[63:0], exp1[1027:960], exp1[63:0]);
    else n_pass++;
    @(posedge clk); #1;
    st0 = 1'b0;
    held = (r0 === exp1);
    ok2 = 1'b0;
    gap = 0;
    for (int g = 2; g <= 100; g++) begin
      @(posedge clk); #1;
      if (dn0) begin ok2 = 1'b1; gap = g; break; end
      if (r0 !== exp1) held = 1'b0;
    end
    $display("b2b op2 ok=%0d gap=%0d", ok2, gap);
    n_total++;
    if (ok2 !== 1'b1 || gap !== 10) $display("FAIL b2b_second_gap: ok=%0d gap got %0d, expected 10", ok2, gap); else n_pass++;
    n_total++;
    if (held !== 1'b1) $display("FAIL b2b_result_held: got %b, expected 1", held); else n_pass++;
    n_total++;
    if (r0 !== exp2)
      $display("FAIL b2b_second_result: got hi=%h lo=%h, expected hi=%h lo=%h", r0[1027:960], r0[63:0], exp2[1027:960], exp2[63:0]);
    else n_pass++;

    xa3 = rand_op(1027); xb3 = rand_op(1027); s3 = 1'($urandom_range(0, 1));
    exp3 = ref_model(1027, xa3, xb3, s3);
    @(posedge clk); #1;
    drive(0, xa3, xb3, s3);
    st0 = 1'b1;
    @(posedge clk); #1;
    st0 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    drive(0, rand_op(1027), rand_op(1027), ~s3);
    st0 = 1'b1;
    @(posedge clk); #1;
    st0 = 1'b0;
    ok = 1'b0;
    lat = 0;
    for (int e = 4; e <= 100; e++) begin
      @(posedge clk); #1;
      if (dn0) begin ok = 1'b1; lat = e + 1; break; end
    end
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (dn0) extra++;
    end
    $display("mid-run start pulse ok=%0d lat=%0d extra_done=%0d", ok, lat, extra);
    n_total++;
    if (ok !== 1'b1 || lat !== 10) $display("FAIL ignore_start_latency: ok=%0d lat got %0d, expected 10", ok, lat); else n_pass++;
    n_total++;
    if (r0 !== exp3)
      $display("FAIL ignore_start_result: got hi=%h lo=%h, expected hi=%h lo=%h", r0[1027:960], r0[63:0], exp3[1027:960], exp3[63:0]);
    else n_pass++;
    n_total++;
    if (extra !== 0) $display("FAIL ignore_start_extra_done: got %0d, expected 0", extra); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [1027:0] res;
    int lat, bc;
    bit ok;
    drive(0, '1, 1027'd12345, 1'b0);
    st0 = 1'b1;
    @(posedge clk); #1;
    st0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    $display("reset asserted mid-run");
    n_total++;
    if (r0 !== 1028'd0) $display("FAIL midreset_result: got lo=%h, expected 0", r0[63:0]); else n_pass++;
    n_total++;
    if (dn0 !== 1'b0) $display("FAIL midreset_done: got %b, expected 0", dn0); else n_pass++;
    n_total++;
    if (bz0 !== 1'b0) $display("FAIL midreset_busy: got %b, expected 0", bz0); else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    run_op(0, 1027'd3, 1027'd4, 1'b0, res, lat, bc, ok);
    $display("add 3+4 after reset ok=%0d lat=%0d", ok, lat);
    n_total++;
    if (res !== 1028'd7) $display("FAIL post_reset_add: got lo=%h, expected 7", res[63:0]); else n_pass++;
  endtask

  task automatic test_random(input int k, input int n_ops);
    logic [1026:0] a, b;
    logic [1027:0] res, exp;
    int w, lat, bc;
    bit sub, ok;
    w = cfg_width(k);
    @(posedge clk); #1;
    for (int i = 0; i < n_ops; i++) begin
      a = rand_op(w);
      b = rand_op(w);
      sub = 1'($urandom_range(0, 1));
      exp = ref_model(w, a, b, sub);
      run_op(k, a, b, sub, res, lat, bc, ok);
      $display("rand cfg%0d op%0d sub=%0d lat=%0d match=%0d", k, i, sub, lat, res === exp);
      n_total++;
      if (ok !== 1'b1) begin
        $display("FAIL rand_cfg%0d_timeout: op %0d done not seen, expected within 2000 cycles", k, i);
        break;
      end else n_pass++;
      n_total++;
      if (res !== exp)
        $display("FAIL rand_cfg%0d_result op%0d: got hi=%h lo=%h, expected hi=%h lo=%h",
                 k, i, res[1027:960], res[63:0], exp[1027:960], exp[63:0]);
      else n_pass++;
      if (i == 0) begin
        n_total++;
        if (lat !== cfg_nchunk(k) + 1)
          $display("FAIL rand_cfg%0d_latency: got %0d, expected %0d", k, lat, cfg_nchunk(k) + 1);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_subtract();
    test_ripple();
    test_back_to_back();
    test_reset_mid();
    for (int k = 0; k < 4; k++) test_random(k, 1500);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
